counter_run_scheduler: RTL and testbench
========================================

// Module: counter_run_scheduler
// PURPOSE
//  Shares one `counter` instance between NumReq requesters. Each requester asks for a
//  counting run to a target value. A round-robin arbiter grants one run at a time.
//  The scheduler drives the counter's reset to clear, release and re-park it.
//  It compares the counter's count output against the granted target and reports
//  completion. Sits beside `counter` in benches and designs; count output is an input here.
// PARAMETERS
//  Size    5  width of counter count / targets (must match counter Size)
//  NumReq  4  number of requesters (>=2)
//  IdW     2  requester id width = clog2(NumReq) (derived, not overridden)
// PORTS
//  clock       in   1           single clock, rising edge
//  reset       in   1           synchronous, active-high
//  req_valid   in   NumReq      per-requester run request; held until req_ready seen
//  req_target  in   NumReq*Size flattened targets; slice i = [i*Size +: Size]
//  req_ready   out  NumReq      one-hot, 1-cycle accept pulse to granted requester
//  abort       in   1           terminate current run early
//  ctr_reset   out  1           drives counter .reset
//  ctr_count   in   Size        from counter .count
//  busy        out  1           run in progress (CLEAR/RUN/DONE)
//  done        out  1           1-cycle completion pulse
//  done_id     out  IdW         requester that owned finished run
//  done_count  out  Size        count sampled at completion
//  done_abort  out  1           run ended by abort, not target match
// BEHAVIOUR
//  Reset: state=IDLE, ctr_reset=1, req_ready=0, busy=0, done=0, done_id=0,
//    done_count=0, done_abort=0, rr pointer=0. All outputs are registered.
//  States:
//   IDLE  - ctr_reset=1. If any req_valid at edge E0: pick winner round-robin from pointer
//     upward, capture its target and id, pointer<=winner+1 (mod NumReq), go CLEAR.
//     No req_valid: stay in IDLE.
//   CLEAR - 1 cycle, req_ready[winner]=1, ctr_reset=1 (counter sees it at E1 -> count=0).
//     abort at E1 -> DONE, done_abort=1. Else -> RUN.
//   RUN   - ctr_reset=0; counter increments each edge. At an edge where ctr_count==target:
//     -> DONE with done_count=ctr_count, done_abort=0, and ctr_reset<=1.
//     Counter overshoots by one at that edge; this is harmless.
//     At an edge where abort=1 (priority over match): -> DONE, done_abort=1,
//     done_count=ctr_count.
//   DONE  - 1 cycle: done=1, done_id valid, ctr_reset=1; -> IDLE.
//  Latency: target T accepted at E0 -> done high during the cycle after edge E0+T+2.
//  T=0 -> done after E0+2 with done_count=0.
//  Targets are full Size range (0..2^Size-1); match is equality only. No wrap is ever
//    needed because count starts at 0.
//  req_valid/req_target are sampled only in IDLE. Changes after the accept edge are ignored.
//  A requester's run is committed once accepted; dropping req_valid does not cancel it.
//  Back-to-back runs: next accept no earlier than the edge leaving DONE
//    (min 1 IDLE cycle between runs).
//  abort is ignored in IDLE and DONE.
//  Synchronous reset in any state -> IDLE next edge. No done pulse is issued and the
//    pointer returns to 0.
//  busy=1 in CLEAR, RUN and DONE.
// STRUCTURE
//  Package counter_sched_pkg: state enum {IDLE,CLEAR,RUN,DONE}, clog2 function for IdW.
//  Sub-module rr_arbiter (NumReq): req vector + pointer in -> one-hot grant + encoded id.
//  Combinational; the pointer register lives in the scheduler.
//  Top holds the FSM, target/id capture registers, comparator and output registers.
// TESTING (bench instantiates counter Size=5 with the scheduler; clock period 10)
//  1 req_valid[2], target 5 -> req_ready[2] pulses 1 cycle; done 7 edges after accept;
//    done_id=2, done_count=5, done_abort=0.
//  2 req_valid[0], target 0 -> done 2 edges after accept, done_count=0.
//  3 All 4 requesters held valid, target 3 -> grant order 0,1,2,3,0; one done per run,
//    ids match grant order.
//  4 target 31 (max) -> done_count=31, done_abort=0, ctr_reset high in DONE.
//  5 target 20, abort pulsed when count=4 -> done_abort=1, done_count=4; next cycle IDLE.
//  6 reset asserted mid-RUN -> next edge IDLE, ctr_reset=1, busy=0, no done;
//    next grant starts from requester 0.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter run scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    // Ceiling log2 for widths; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdW    = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdW-1:0]    ptr,
    output logic [NumReq-1:0] grant,
    output logic [IdW-1:0]    id,
    output logic              valid
);

    logic [IdW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = IdW'((int'(ptr) + k) % NumReq);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_run_scheduler.sv
// Time-shares one external counter between NumReq requesters, one counting run at a time.
module counter_run_scheduler
    import counter_sched_pkg::*;
#(
    parameter  int Size   = 5,
    parameter  int NumReq = 4,
    localparam int IdW    = clog2(NumReq)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NumReq-1:0]      req_valid,
    input  logic [NumReq*Size-1:0] req_target,
    output logic [NumReq-1:0]      req_ready,
    input  logic                   abort,
    output logic                   ctr_reset,
    input  logic [Size-1:0]        ctr_count,
    output logic                   busy,
    output logic                   done,
    output logic [IdW-1:0]         done_id,
    output logic [Size-1:0]        done_count,
    output logic                   done_abort
);

    state_t            state;
    logic [IdW-1:0]    ptr;
    logic [IdW-1:0]    next_ptr;
    logic [NumReq-1:0] win_grant;
    logic [IdW-1:0]    win_id;
    logic              win_valid;
    logic [Size-1:0]   sel_target;
    logic [IdW-1:0]    cur_id;
    logic [Size-1:0]   cur_target;
    logic              finish_run;

    rr_arbiter #(.NumReq(NumReq)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .id    (win_id),
        .valid (win_valid)
    );

    assign sel_target = req_target[int'(win_id)*Size +: Size];
    assign next_ptr   = (win_id == IdW'(NumReq - 1)) ? '0 : win_id + 1'b1;

    // Abort outranks a simultaneous target match; in CLEAR only abort can end the run.
    assign finish_run = abort || (state == RUN && ctr_count == cur_target);

    always_ff @(posedge clock) begin
        // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_id     <= '0;
            cur_target <= '0;
            ctr_reset  <= 1'b1;
            req_ready  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            done_count <= '0;
            done_abort <= 1'b0;
        end else begin
            req_ready <= '0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    ctr_reset <= 1'b1;
                    if (win_valid) begin
                        state      <= CLEAR;
                        cur_id     <= win_id;
                        cur_target <= sel_target;
                        ptr        <= next_ptr;
                        req_ready  <= win_grant;
                        busy       <= 1'b1;
                    end
                end
                CLEAR, RUN: begin
                    if (finish_run) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        done_id    <= cur_id;
                        done_count <= ctr_count;
                        done_abort <= abort;
                        ctr_reset  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        ctr_reset <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ctr_reset <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ctr_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Self-checking bench: scheduler plus a behavioural 5-bit counter, table, directed and random runs.
module tb_counter_run_scheduler;

    localparam int Size   = 5;
    localparam int NumReq = 4;

    logic                   clock;
    logic                   reset;
    logic [NumReq-1:0]      req_valid;
    logic [NumReq*Size-1:0] req_target;
    logic [NumReq-1:0]      req_ready;
    logic                   abort;
    logic                   ctr_reset;
    logic [Size-1:0]        ctr_count;
    logic                   busy;
    logic                   done;
    logic [1:0]             done_id;
    logic [Size-1:0]        done_count;
    logic                   done_abort;

    int n_checks = 0;
    int n_fails  = 0;
    int ptr_m    = 0;

    counter_run_scheduler #(.Size(Size), .NumReq(NumReq)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (req_ready),
        .abort      (abort),
        .ctr_reset  (ctr_reset),
        .ctr_count  (ctr_count),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .done_count (done_count),
        .done_abort (done_abort)
    );

    // Stand-in for the shared counter: sync reset to 0, else increment each edge.
    always_ff @(posedge clock) begin
        if (ctr_reset) ctr_count <= '0;
        else           ctr_count <= ctr_count + 5'd1;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int req;       // sole requester asserting valid
        int tgt;
        int abort_at;  // count value at which abort is sampled; -1 none, -2 during CLEAR
        int lat;       // edges from accept edge to done
        int cnt;       // expected done_count, -1 = not checked
        bit ab;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] mask, input int p);
        for (int k = 0; k < NumReq; k++) begin
            if (mask[(p + k) % NumReq]) return (p + k) % NumReq;
        end
        return -1;
    endfunction

    // One complete run: present requests, wait for accept, optionally abort, then check done and return to IDLE.
    task automatic do_run(input string nm, input logic [3:0] mask, input logic [19:0] tg,
                          input bit hold, input int abort_at, input int exp_id,
                          input int exp_lat, input int exp_cnt, input bit exp_ab);
        int waited;
        int lat;
        req_valid = mask;
        req_target = tg;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (req_ready == '0 && waited < 50);
        check($sformatf("%s req_ready", nm), 32'(req_ready), 32'(4'b0001 << exp_id));
        check($sformatf("%s busy at accept", nm), 32'(busy), 32'd1);
        ptr_m = (exp_id + 1) % NumReq;
        if (!hold) begin
            req_valid  = '0;
            req_target = 20'($urandom);
        end
        abort = (abort_at == -2);
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) check($sformatf("%s ready pulse", nm), 32'(req_ready), 32'd0);
            abort = (abort_at >= 0 && lat == abort_at + 1);
        end while (!done && lat < 80);
        abort = 1'b0;
        check($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat));
        check($sformatf("%s done_id", nm), 32'(done_id), 32'(exp_id));
        if (exp_cnt >= 0) check($sformatf("%s done_count", nm), 32'(done_count), 32'(exp_cnt));
        check($sformatf("%s done_abort", nm), 32'(done_abort), 32'(exp_ab));
        check($sformatf("%s ctr_reset in DONE", nm), 32'(ctr_reset), 32'd1);
        tick();
        check($sformatf("%s done pulse", nm), 32'(done), 32'd0);
        check($sformatf("%s idle busy", nm), 32'(busy), 32'd0);
        check($sformatf("%s no accept leaving DONE", nm), 32'(req_ready), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int ids[5];
        int dones;
        logic [3:0]  mask;
        logic [19:0] tg;
        int win, t, a;

        vecs[0] = '{2, 5, -1, 7, 5, 1'b0};
        vecs[1] = '{0, 0, -1, 2, 0, 1'b0};
        vecs[2] = '{1, 31, -1, 33, 31, 1'b0};
        vecs[3] = '{3, 20, 4, 6, 4, 1'b1};
        vecs[4] = '{0, 10, 10, 12, 10, 1'b1};
        vecs[5] = '{1, 9, -2, 1, -1, 1'b1};
        vecs[6] = '{3, 0, 0, 2, 0, 1'b1};
        ids = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        req_valid = '0;
        req_target = '0;
        abort = 1'b0;
        tick();
        tick();
        check("reset ctr_reset", 32'(ctr_reset), 32'd1);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset done_id", 32'(done_id), 32'd0);
        check("reset done_count", 32'(done_count), 32'd0);
        check("reset done_abort", 32'(done_abort), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            tg = 20'($urandom);
            tg[vecs[i].req*Size +: Size] = 5'(vecs[i].tgt);
            do_run($sformatf("vec%0d", i), 4'(1 << vecs[i].req), tg, 1'b0,
                   vecs[i].abort_at, vecs[i].req, vecs[i].lat, vecs[i].cnt, vecs[i].ab);
        end

        // Reset in the middle of a long run: no done, pointer back to 0.
        req_valid = 4'b0100;
        req_target = '0;
        req_target[2*Size +: Size] = 5'd20;
        dones = 0;
        for (int i = 0; i < 10 && req_ready == '0; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr_m = 0;
        check("midrun reset ctr_reset", 32'(ctr_reset), 32'd1);
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset done", 32'(done), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) dones++;
        end
        check("midrun reset no done", 32'(dones), 32'd0);
        check("midrun reset parked", 32'(busy), 32'd0);

        // All requesters held valid: strict rotation starting from 0.
        tg = {5'd3, 5'd3, 5'd3, 5'd3};
        for (int i = 0; i < 5; i++) begin
            do_run($sformatf("rr%0d", i), 4'hF, tg, 1'b1, -1, ids[i], 5, 3, 1'b0);
        end
        req_valid = '0;
        tick();

        // Random traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            tg = 20'($urandom);
            win = rr_pick(mask, ptr_m);
            t = int'(tg[win*Size +: Size]);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t)) : -1;
            if (a >= 0)
                do_run($sformatf("rand%0d", i), mask, tg, 1'b0, a, win, a + 2, a, 1'b1);
            else
                do_run($sformatf("rand%0d", i), mask, tg, 1'b0, -1, win, t + 2, t, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
